// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through, read-allocate cache controller with one-word lines.
// Define DM_CACHE_STATS_EN to add saturating hit/miss counters (stat_hits, stat_misses).
module dm_cache_ctrl #(
  parameter int unsigned ADDR_LENGTH = 16,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned LINES       = 16
`ifdef DM_CACHE_STATS_EN
  , parameter int unsigned STAT_WIDTH = 16
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cpu_req_valid,
  output logic                   cpu_req_ready,
  input  logic                   cpu_req_we,
  input  logic [ADDR_LENGTH-1:0] cpu_req_addr,
  input  logic [DATA_WIDTH-1:0]  cpu_req_wdata,
  output logic                   cpu_rsp_valid,
  output logic [DATA_WIDTH-1:0]  cpu_rsp_rdata,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic                   mem_req_we,
  output logic [ADDR_LENGTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0]  mem_req_wdata,
  input  logic                   mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]  mem_rsp_rdata
`ifdef DM_CACHE_STATS_EN
  , output logic [STAT_WIDTH-1:0] stat_hits,
  output logic [STAT_WIDTH-1:0]   stat_misses
`endif
);

  localparam int unsigned INDEX_BITS = $clog2(LINES);
  localparam int unsigned TAG_BITS   = ADDR_LENGTH - INDEX_BITS;

  typedef enum logic [2:0] {StIdle, StLookup, StMemRd, StMemWait, StMemWr} state_e;

  state_e                 r_state;
  logic                   r_we;
  logic [ADDR_LENGTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]  r_wdata;
  logic [LINES-1:0]       r_valid;
  logic [TAG_BITS-1:0]    r_tag  [LINES];
  logic [DATA_WIDTH-1:0]  r_data [LINES];

  logic                   r_cpu_req_ready;
  logic                   r_cpu_rsp_valid;
  logic [DATA_WIDTH-1:0]  r_cpu_rsp_rdata;
  logic                   r_mem_req_valid;
  logic                   r_mem_req_we;
  logic [ADDR_LENGTH-1:0] r_mem_req_addr;
  logic [DATA_WIDTH-1:0]  r_mem_req_wdata;

  logic [INDEX_BITS-1:0]  w_index;
  logic [TAG_BITS-1:0]    w_tag;
  logic                   w_hit;
  logic                   w_refill;
  logic                   w_wr_hit;

  assign w_index  = r_addr[INDEX_BITS-1:0];
  assign w_tag    = r_addr[ADDR_LENGTH-1:INDEX_BITS];
  assign w_hit    = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_refill = (r_state == StMemWait) && mem_rsp_valid;
  assign w_wr_hit = (r_state == StLookup) && r_we && w_hit;

  // Tag/data storage is deliberately not reset; the valid bits gate every use.
  always_ff @(posedge clk) begin
    if (w_refill) begin
      r_tag[w_index]  <= w_tag;
      r_data[w_index] <= mem_rsp_rdata;
    end else if (w_wr_hit) begin
      r_data[w_index] <= r_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= StIdle;
      r_we            <= 1'b0;
      r_addr          <= '0;
      r_wdata         <= '0;
      r_valid         <= '0;
      r_cpu_req_ready <= 1'b0;
      r_cpu_rsp_valid <= 1'b0;
      r_cpu_rsp_rdata <= '0;
      r_mem_req_valid <= 1'b0;
      r_mem_req_we    <= 1'b0;
      r_mem_req_addr  <= '0;
      r_mem_req_wdata <= '0;
    end else begin
      r_cpu_rsp_valid <= 1'b0;
      r_cpu_rsp_rdata <= '0;
      unique case (r_state)
        StIdle: begin
          r_cpu_req_ready <= 1'b1;
          if (cpu_req_valid && r_cpu_req_ready) begin
            r_we            <= cpu_req_we;
            r_addr          <= cpu_req_addr;
            r_wdata         <= cpu_req_wdata;
            r_cpu_req_ready <= 1'b0;
            r_state         <= StLookup;
          end
        end
        StLookup: begin
          if (!r_we && w_hit) begin
            r_cpu_rsp_valid <= 1'b1;
            r_cpu_rsp_rdata <= r_data[w_index];
            r_cpu_req_ready <= 1'b1;
            r_state         <= StIdle;
          end else begin
            // Every write goes through to memory; read misses fetch the word.
            r_mem_req_valid <= 1'b1;
            r_mem_req_we    <= r_we;
            r_mem_req_addr  <= r_addr;
            r_mem_req_wdata <= r_we ? r_wdata : '0;
            r_state         <= r_we ? StMemWr : StMemRd;
          end
        end
        StMemRd: begin
          if (mem_req_ready) begin
            r_mem_req_valid <= 1'b0;
            r_state         <= StMemWait;
          end
        end
        StMemWait: begin
          if (mem_rsp_valid) begin
            r_valid[w_index] <= 1'b1;
            r_cpu_rsp_valid  <= 1'b1;
            r_cpu_rsp_rdata  <= mem_rsp_rdata;
            r_cpu_req_ready  <= 1'b1;
            r_state          <= StIdle;
          end
        end
        StMemWr: begin
          if (mem_req_ready) begin
            r_mem_req_valid <= 1'b0;
            r_mem_req_we    <= 1'b0;
            r_cpu_rsp_valid <= 1'b1;
            r_cpu_req_ready <= 1'b1;
            r_state         <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign cpu_req_ready = r_cpu_req_ready;
  assign cpu_rsp_valid = r_cpu_rsp_valid;
  assign cpu_rsp_rdata = r_cpu_rsp_rdata;
  assign mem_req_valid = r_mem_req_valid;
  assign mem_req_we    = r_mem_req_we;
  assign mem_req_addr  = r_mem_req_addr;
  assign mem_req_wdata = r_mem_req_wdata;

`ifdef DM_CACHE_STATS_EN
  logic [STAT_WIDTH-1:0] r_hits;
  logic [STAT_WIDTH-1:0] r_misses;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hits   <= '0;
      r_misses <= '0;
    end else if (r_state == StLookup) begin
      if (w_hit && (r_hits != '1)) begin
        r_hits <= r_hits + 1'b1;
      end else if (!w_hit && (r_misses != '1)) begin
        r_misses <= r_misses + 1'b1;
      end
    end
  end

  assign stat_hits   = r_hits;
  assign stat_misses = r_misses;
`endif

endmodule

// File: doc/dm_cache_ctrl.md
Name: dm_cache_ctrl

Overview:
- Parametrised direct-mapped cache controller between the CPU request channel and the memory controller. Generalises the fixed 16-bit cpu/cache address channel.
- Adds the following:
  - configurable address width, data width and line count
  - valid/ready handshakes on both sides
  - tag/valid array
  - write-through, read-allocate miss handling FSM
- One-word lines; word-addressed.

Parameters:
ADDR_LENGTH, 16, word-address width on CPU and memory sides
DATA_WIDTH, 32, data word width
LINES, 16, number of cache lines (power of two, >=2); INDEX_BITS=$clog2(LINES), TAG_BITS=ADDR_LENGTH-INDEX_BITS
STAT_WIDTH, 16, width of statistics counters (optional feature only)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
cpu_req_valid  input  1  CPU request present
cpu_req_ready  output  1  controller accepts request
cpu_req_we  input  1  1=write, 0=read
cpu_req_addr  input  ADDR_LENGTH  word address
cpu_req_wdata  input  DATA_WIDTH  write data
cpu_rsp_valid  output  1  one-cycle response pulse
cpu_rsp_rdata  output  DATA_WIDTH  read data (0 for write acks)
mem_req_valid  output  1  memory request present
mem_req_ready  input  1  memory accepts request
mem_req_we  output  1  memory write
mem_req_addr  output  ADDR_LENGTH  memory word address
mem_req_wdata  output  DATA_WIDTH  memory write data
mem_rsp_valid  input  1  memory read data valid, one cycle
mem_rsp_rdata  input  DATA_WIDTH  memory read data

Behaviour:
- Reset (async, rst_n=0):
  - all valid bits cleared; FSM to IDLE.
  - cpu_req_ready=0 while in reset, 1 in IDLE after release.
  - cpu_rsp_valid=0, cpu_rsp_rdata=0.
  - mem_req_valid=0, mem_req_we=0, mem_req_addr=0, mem_req_wdata=0.
  - Tag/data arrays are not reset.
- Address split: index=addr[INDEX_BITS-1:0], tag=addr[ADDR_LENGTH-1:INDEX_BITS].
- FSM states are IDLE, LOOKUP, MEM_RD, MEM_WAIT, MEM_WR.
- IDLE:
  - cpu_req_ready=1.
  - On cpu_req_valid&&cpu_req_ready, latch we/addr/wdata and go to LOOKUP.
  - cpu_req_ready=0 in every other state (one outstanding request).
- LOOKUP: hit = valid[index] && tag match.
  - Read hit: cpu_rsp_valid=1 with line data, go to IDLE. Response appears on the 2nd edge after acceptance.
  - Read miss: go to MEM_RD.
  - Write hit: update line data in this cycle, go to MEM_WR.
  - Write miss: no allocate, go to MEM_WR.
- MEM_RD:
  - mem_req_valid=1, we=0, addr=latched addr.
  - On mem_req_ready go to MEM_WAIT.
- MEM_WAIT:
  - On mem_rsp_valid, write tag, data and valid=1 into the line.
  - Same cycle: pulse cpu_rsp_valid with rdata=mem_rsp_rdata, go to IDLE.
- MEM_WR:
  - mem_req_valid=1, we=1, addr/wdata=latched values.
  - On mem_req_ready, pulse cpu_rsp_valid (rdata=0), go to IDLE.
- Memory request rules:
  - While mem_req_valid=1 and mem_req_ready=0, mem_req_* are held stable.
  - mem_req_valid is never withdrawn before acceptance, except by reset.
- cpu_rsp_valid is a single-cycle pulse; the CPU cannot stall responses.
- Reset mid-operation: transaction abandoned, no response issued. A line being refilled stays invalid.
- Simultaneous mem_req_ready and mem_rsp_valid in MEM_RD: mem_rsp_valid is ignored; memory never responds in the acceptance cycle.

Optional Feature:
- Macro: DM_CACHE_STATS_EN.
- When defined:
  - Adds output ports stat_hits, stat_misses, both STAT_WIDTH.
  - Hits increment on LOOKUP hit (read or write); misses increment on LOOKUP miss.
  - Counters saturate at all-ones, clear to 0 on reset.
- When undefined: ports and counters are absent; behaviour otherwise identical.

Test Plan:
(LINES=16, ADDR_LENGTH=16, DATA_WIDTH=32)
1. Read 0x0010 after reset -> mem read to 0x0010; memory returns 0xDEADBEEF -> cpu_rsp_rdata=0xDEADBEEF. Reread 0x0010 -> response 2 cycles after accept, no mem_req_valid.
2. Read 0x0010 (cached), then 0x0020 (same index 0) -> miss and refill. Read 0x0010 again -> miss, mem read 0x0010.
3. Cached 0x0010, write 0x12345678 -> mem write addr 0x0010 data 0x12345678, ack rdata=0. Read 0x0010 -> hit 0x12345678.
4. Write 0x0035 = 0xA5A5A5A5 uncached -> mem write, no allocate. Read 0x0035 -> miss, mem read issued.
5. mem_req_ready low 5 cycles during a miss -> mem_req_valid/addr stable all 5 cycles; cpu_req_ready=0 throughout; proceeds on first ready.
6. rst_n low during MEM_WAIT -> all outputs at reset values immediately. After release, read of a previously cached address misses. With DM_CACHE_STATS_EN, stat_hits=stat_misses=0.
